// File: rtl/sba_pkg.sv
// rtl/sba_pkg.sv - shared widths, state encoding and master ids for the SBA arbiter
//
// Purpose: common definitions imported by sba_arbiter and sba_watchdog.
//   ADDR_W/DAT_W/WE_W : SBA bus field widths
//   sba_state_e       : arbiter states IDLE/GNT0/GNT1/TURN
//   M0/M1             : master ids as stored in the last-grant register
package sba_pkg;

  localparam int ADDR_W = 32;
  localparam int DAT_W  = 32;
  localparam int WE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    TURN = 2'd3
  } sba_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/sba_watchdog.sv
// rtl/sba_watchdog.sv - saturating cycle counter that flags a hung transaction
//
// Purpose: counts granted cycles of one transaction; o_expire is high while the
// count equals TIMEOUT-1, i.e. during the TIMEOUT-th strobe cycle.
// Ports:
//   i_clk     in  1  clock
//   i_rst     in  1  synchronous reset, active-low
//   i_clear   in  1  zero the counter (held while the arbiter is idle)
//   i_enable  in  1  count this cycle (arbiter is in a grant state)
//   o_expire  out 1  count has reached TIMEOUT-1
module sba_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  logic [TO_W-1:0] cnt;

  // Saturates at all-ones so a long stall can never wrap back to a fresh count.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (i_clear) begin
      cnt <= '0;
    end else if (i_enable && (cnt != {TO_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_expire = (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/sba_arbiter.sv
// rtl/sba_arbiter.sv - round-robin two-master arbiter for the SBA slave port
//
// Purpose: shares one SBA slave port between M0 (CPU) and M1 (DMA master). A grant
// lasts one whole transaction, is followed by one bus-idle turnaround cycle, and a
// watchdog ends transactions the slave never acknowledges with an error ack.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-low reset
//   i_mX_stb/we/addr/dat_w            master X request, held until o_mX_ack
//   o_mX_dat_r/ack/err                master X response (ack is a 1-cycle pulse,
//                                     err qualifies it as a watchdog termination)
//   o_stb/we/addr/dat_w               slave-side request of the granted master
//   i_dat_r, i_ack                    slave response (already address-decoded)
module sba_arbiter
  import sba_pkg::*;
#(
  parameter int               TIMEOUT  = 64,
  parameter int               TO_W     = 7,
  parameter logic [DAT_W-1:0] ERR_DATA = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_stb,
  input  logic [WE_W-1:0]   i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DAT_W-1:0]  i_m0_dat_w,
  output logic [DAT_W-1:0]  o_m0_dat_r,
  output logic              o_m0_ack,
  output logic              o_m0_err,
  input  logic              i_m1_stb,
  input  logic [WE_W-1:0]   i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DAT_W-1:0]  i_m1_dat_w,
  output logic [DAT_W-1:0]  o_m1_dat_r,
  output logic              o_m1_ack,
  output logic              o_m1_err,
  output logic              o_stb,
  output logic [WE_W-1:0]   o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DAT_W-1:0]  o_dat_w,
  input  logic [DAT_W-1:0]  i_dat_r,
  input  logic              i_ack
);

  sba_state_e        state, state_nxt;
  logic              last, last_nxt;
  logic              wd_clear, wd_enable, wd_expire;
  logic              sel;
  logic              m_stb;
  logic [WE_W-1:0]   m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DAT_W-1:0]  m_dat_w;
  logic [DAT_W-1:0]  rsp_dat;

  sba_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (wd_clear),
    .i_enable (wd_enable),
    .o_expire (wd_expire)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      last  <= M1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Fields of whichever master the current grant state belongs to.
  always_comb begin
    sel     = (state == GNT1);
    m_stb   = sel ? i_m1_stb   : i_m0_stb;
    m_we    = sel ? i_m1_we    : i_m0_we;
    m_addr  = sel ? i_m1_addr  : i_m0_addr;
    m_dat_w = sel ? i_m1_dat_w : i_m0_dat_w;
    // A real slave ack beats a same-cycle watchdog expiry.
    rsp_dat = i_ack ? i_dat_r : ERR_DATA;
  end

  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    o_stb      = 1'b0;
    o_we       = '0;
    o_addr     = '0;
    o_dat_w    = '0;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m0_dat_r = '0;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    o_m1_dat_r = '0;

    case (state)
      IDLE: begin
        wd_clear = 1'b1;
        if (i_m0_stb && i_m1_stb) begin
          state_nxt = (last == M0) ? GNT1 : GNT0;
        end else if (i_m0_stb) begin
          state_nxt = GNT0;
        end else if (i_m1_stb) begin
          state_nxt = GNT1;
        end
      end

      GNT0, GNT1: begin
        wd_enable = 1'b1;
        o_stb     = m_stb;
        o_we      = m_we;
        o_addr    = m_addr;
        o_dat_w   = m_dat_w;
        if (!m_stb) begin
          // Master abandoned the request: release the bus without an ack.
          state_nxt = TURN;
        end else if (i_ack || wd_expire) begin
          last_nxt  = sel;
          state_nxt = TURN;
          if (sel == M1) begin
            o_m1_ack   = 1'b1;
            o_m1_err   = !i_ack;
            o_m1_dat_r = rsp_dat;
          end else begin
            o_m0_ack   = 1'b1;
            o_m0_err   = !i_ack;
            o_m0_dat_r = rsp_dat;
          end
        end
      end

      // One strobe-free cycle lets registered slave acks fall before the next grant.
      TURN: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

endmodule
